input_port_ctrl: RTL

//   Producer side of the CPU input-port handshake: turns a raw push button and
//   raw switches into a clean, one-byte-per-press data word plus ready level for
//   the CPU's ready_in/in_port inputs. Holds the word and ready until the CPU

---
 rtl/input_port_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/input_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : input_port_ctrl
// Purpose  : Debounced push-button / switch-bank producer for the CPU input
//            port handshake: one captured word per press, held until taken.
// Revision : 1.0 - initial release
// ============================================================================
module input_port_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             btn_raw,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             data_taken,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    localparam int                 c_CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_PRESS    = 2'd1;
    localparam logic [1:0] c_READY    = 2'd2;
    localparam logic [1:0] c_WAIT_REL = 2'd3;

    logic             r_btn_meta;
    logic             r_btn_s;
    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_s;
    logic [1:0]       r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_capture;

    // Two-flop synchronisers; the switch bank only needs to be quiet around
    // the capture, so per-bit synchronisation is sufficient.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
        end else begin
            r_btn_meta <= btn_raw;
            r_btn_s    <= r_btn_meta;
            r_sw_meta  <= sw_raw;
            r_sw_s     <= r_sw_meta;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_data <= r_sw_s;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = c_PRESS;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            c_PRESS: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = c_READY;
                    w_cnt_nxt   = '0;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_READY: begin
                if (data_taken) begin
                    w_state_nxt = c_WAIT_REL;
                    w_cnt_nxt   = '0;
                end
            end
            c_WAIT_REL: begin
                // Release must be seen DB_CYCLES samples in a row; any
                // re-press restarts the count so a held button never re-arms.
                if (r_btn_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_CNT_MAX - c_CNT_ONE) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ready_out = (r_state == c_READY);
        busy      = (r_state != c_IDLE);
    end

    assign data_out = r_data;

endmodule
`default_nettype wire
